// File: rtl/div_pipe_signed.sv
// Pipelined restoring divider (DIV/DIVU/REM/REMU) carrying tag and PC alongside each op.
// Latency: popcount(STAGE_MASK) cycles from accept to out_valid; one op per cycle when not stalled.
// Backpressure: out_valid & ~out_ready freezes every stage and drops in_ready; flush clears all valids.
module div_pipe_signed #(
  parameter int              XLEN       = 32,
  parameter int              TAG_W      = 8,
  parameter int              PC_W       = 32,
  parameter logic [XLEN-1:0] STAGE_MASK = 32'h55555555
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_dz,
  output logic [TAG_W-1:0] out_tag,
  output logic [PC_W-1:0]  out_pc
);

  // Everything that travels down the pipe with an op.
  typedef struct packed {
    logic             valid;
    logic [1:0]       op;
    logic             q_neg;
    logic             r_neg;
    logic             dz;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  pc;
    logic [XLEN-1:0]  rem;   // partial remainder
    logic [XLEN-1:0]  quo;   // quotient bits produced so far
    logic [XLEN-1:0]  num;   // dividend magnitude
    logic [XLEN-1:0]  den;   // divisor magnitude
  } stage_t;

  // One restoring step: bring down dividend bit XLEN-1-k, subtract divisor if it fits.
  function automatic stage_t iterate(input stage_t s, input int k);
    stage_t          o;
    logic [XLEN:0]   trial;
    o     = s;
    trial = {s.rem, s.num[XLEN-1-k]};
    if (trial >= {1'b0, s.den}) begin
      trial             = trial - {1'b0, s.den};
      o.quo[XLEN-1-k]   = 1'b1;
    end
    o.rem = trial[XLEN-1:0];
    return o;
  endfunction

  logic   stall;
  stage_t in_st;
  stage_t last;
  logic   signed_op;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Input stage: take magnitudes for signed ops and remember the result signs.
  always_comb begin
    in_st       = '0;
    signed_op   = ~in_op[0];
    in_st.valid = in_valid & in_ready;
    in_st.op    = in_op;
    in_st.tag   = in_tag;
    in_st.pc    = in_pc;
    in_st.dz    = (in_b == '0);
    in_st.q_neg = signed_op & (in_a[XLEN-1] ^ in_b[XLEN-1]);
    in_st.r_neg = signed_op & in_a[XLEN-1];
    in_st.num   = (signed_op & in_a[XLEN-1]) ? -in_a : in_a;
    in_st.den   = (signed_op & in_b[XLEN-1]) ? -in_b : in_b;
  end

  for (genvar k = 0; k < XLEN; k++) begin : g_iter
    stage_t s_in;
    stage_t s_step;
    stage_t s_out;

    if (k == 0) begin : g_first
      assign s_in = in_st;
    end else begin : g_next
      assign s_in = g_iter[k-1].s_out;
    end

    assign s_step = iterate(s_in, k);

    if (STAGE_MASK[k]) begin : g_reg
      stage_t st_d;
      stage_t st_q;

      // Flush kills the op (data may go stale), stall holds, otherwise advance.
      always_comb begin
        st_d = s_step;
        if (flush) begin
          st_d       = st_q;
          st_d.valid = 1'b0;
        end else if (stall) begin
          st_d = st_q;
        end
      end

      // Stage register.
      always_ff @(posedge clk) begin
        if (reset) st_q <= '0;
        else       st_q <= st_d;
      end

      assign s_out = st_q;
    end else begin : g_comb
      assign s_out = s_step;
    end
  end

  assign last = g_iter[XLEN-1].s_out;

  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic            unused_ok;
  assign unused_ok = ^{last.num, last.den};

  // Sign fix-up and result select; outputs read zero whenever no valid op is presented.
  always_comb begin
    q_fix      = last.dz ? '1 : (last.q_neg ? -last.quo : last.quo);
    // For a zero divisor rem equals |a|, so re-applying the dividend sign gives back a.
    r_fix      = last.r_neg ? -last.rem : last.rem;
    out_valid  = last.valid;
    out_result = '0;
    out_dz     = 1'b0;
    out_tag    = '0;
    out_pc     = '0;
    if (last.valid) begin
      out_result = last.op[1] ? r_fix : q_fix;
      out_dz     = last.dz;
      out_tag    = last.tag;
      out_pc     = last.pc;
    end
  end

endmodule

// File: tb/tb_div_pipe_signed.sv
// Bench for div_pipe_signed: directed vectors plus a queue-based reference model.
// Latency 16 with the default stage mask.
// Exercises stall, flush and reset with ops in flight.
module tb_div_pipe_signed;
  localparam int L = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [7:0]  in_tag;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_dz;
  logic [7:0]  out_tag;
  logic [31:0] out_pc;

  div_pipe_signed dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dz(out_dz), .out_tag(out_tag), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tagc   = 0;

  typedef struct {
    logic [31:0] res;
    logic        dz;
    logic [7:0]  tag;
    logic [31:0] pc;
  } exp_t;
  exp_t exp_q[$];

  // Reference: RISC-V M divide semantics in plain arithmetic. Returns {dz, result}.
  function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return {1'b1, (op[1] ? a : 32'hFFFF_FFFF)};
    if (op[0]) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
    return {1'b0, (op[1] ? r : q)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, req);
    end
  endtask

  // Scoreboard: every presented output must match the oldest outstanding op.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out tag=%0h pc=%0h result=%0h", out_tag, out_pc, out_result);
        end else if ({out_result, out_dz, out_tag, out_pc} !==
                     {exp_q[0].res, exp_q[0].dz, exp_q[0].tag, exp_q[0].pc}) begin
          errors++;
          $display("FAIL scoreboard got res=%0h dz=%0b tag=%0h pc=%0h expected res=%0h dz=%0b tag=%0h pc=%0h",
                   out_result, out_dz, out_tag, out_pc,
                   exp_q[0].res, exp_q[0].dz, exp_q[0].tag, exp_q[0].pc);
        end
        if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (flush) begin
        exp_q.delete();
      end else if (in_valid && in_ready) begin
        logic [32:0] m;
        exp_t e;
        m     = model(in_op, in_a, in_b);
        e.res = m[31:0];
        e.dz  = m[32];
        e.tag = in_tag;
        e.pc  = in_pc;
        exp_q.push_back(e);
      end
    end
  end

  // Single op into an empty pipe; checks latency and the hand-computed result.
  task automatic run_one(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic edz);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    in_tag = tagc[7:0]; in_pc = 32'h1000 + 32'(tagc) * 4; tagc++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(L));
    chk("result", {32'd0, out_result}, {32'd0, er});
    chk("dz", {63'd0, out_dz}, {63'd0, edz});
  endtask

  initial begin
    int ov;
    int guard;
    logic [2:0] sel;
    reset = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0;
    in_tag = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_result", {32'd0, out_result}, 64'd0);
    chk("rst_out_dz", {63'd0, out_dz}, 64'd0);
    chk("rst_out_tag", {56'd0, out_tag}, 64'd0);
    chk("rst_out_pc", {32'd0, out_pc}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Pin the model against hand-computed values.
    chk("model_div_100_7", {31'd0, model(2'b00, 32'd100, 32'd7)}, {31'd0, 1'b0, 32'd14});
    chk("model_rem_neg7_2", {31'd0, model(2'b10, 32'hFFFF_FFF9, 32'd2)}, {31'd0, 1'b0, 32'hFFFF_FFFF});
    chk("model_div_ovf", {31'd0, model(2'b00, 32'h8000_0000, 32'hFFFF_FFFF)}, {31'd0, 1'b0, 32'h8000_0000});
    chk("model_rem_dz", {31'd0, model(2'b10, 32'h1234, 32'd0)}, {31'd0, 1'b1, 32'h1234});

    // Directed vectors.
    run_one(2'b00, 32'd100, 32'd7, 32'd14, 1'b0);
    run_one(2'b10, 32'd100, 32'd7, 32'd2, 1'b0);
    run_one(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_one(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run_one(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0);
    run_one(2'b11, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    run_one(2'b00, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0);
    run_one(2'b00, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b1);
    run_one(2'b01, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b1);
    run_one(2'b10, 32'h1234, 32'd0, 32'h1234, 1'b1);
    run_one(2'b11, 32'h1234, 32'd0, 32'h1234, 1'b1);
    run_one(2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1);
    run_one(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_one(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_one(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
    run_one(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);

    // 40 back-to-back random ops with a 5-cycle consumer stall mid-stream.
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          sel    = 3'($urandom_range(0, 7));
          in_op  = 2'($urandom_range(0, 3));
          in_a   = $urandom;
          case (sel)
            3'd0:    in_b = 32'd0;
            3'd1:    begin in_a = 32'h8000_0000; in_b = 32'hFFFF_FFFF; end
            3'd2:    in_b = 32'hFFFF_FFFF;
            default: in_b = $urandom >> $urandom_range(0, 31);
          endcase
          in_valid = 1'b1;
          in_tag   = tagc[7:0];
          in_pc    = 32'h1000 + 32'(tagc) * 4;
          tagc++;
          guard = 0;
          @(negedge clk);
          while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
          end
          if (guard >= 100) chk("in_ready_timeout", 64'd0, 64'd1);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        repeat (12) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join

    // Flush with ops in flight and a simultaneous op that must be dropped.
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; in_op = 2'b00; in_a = 32'd50; in_b = 32'd5;
    in_tag = 8'hEE; in_pc = 32'hDEAD;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    ov = 0;
    repeat (2 * L + 8) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    chk("quiet_after_flush", 64'(ov), 64'd0);
    run_one(2'b00, 32'd1000, 32'hFFFF_FFF6, 32'hFFFF_FF9C, 1'b0);

    // Reset with an op in flight: nothing may emerge afterwards.
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 2'b01; in_a = 32'd9; in_b = 32'd3;
    in_tag = 8'h55; in_pc = 32'hBEEF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_out_result", {32'd0, out_result}, 64'd0);
    ov = 0;
    repeat (2 * L + 4) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    chk("quiet_after_reset", 64'(ov), 64'd0);
    run_one(2'b11, 32'd100, 32'd7, 32'd2, 1'b0);

    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
